// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  // Default operand width in bits.
  localparam int unsigned DefaultWidth = 4;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Counter restart value: one step fewer than the number of iterations.
  function automatic int unsigned cnt_init(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// Down-counter that paces the multiplier iterations.
// load restarts the count at cnt_init(Width) and wins over step; done is a
// registered flag, high when the count is zero and no strobe was applied in
// the previous cycle.
module mult_step_cnt
  import mult_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic done
);

  localparam int unsigned CntW = (Width > 2) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(cnt_init(Width));

  logic [CntW-1:0] count_q, count_d;
  logic            done_q, done_d;

  // Next count and done flag.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CntLoad;
    end else if (step) begin
      count_d = count_q - 1'b1;
    end
    done_d = (count_q == '0) && !load && !step;
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add controller and datapath for an unsigned sequential multiplier.
// One ADD/SHIFT pair per multiplier bit; an external step counter paces the
// iterations through cnt_load/cnt_step and reports the end through cnt_done.
// Build option: define MULT_INT_CNT_EN to use an internal mult_step_cnt
// instead of the cnt_done port (the strobes are still driven on the ports).
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               cnt_load,
  output logic               cnt_step,
  input  logic               cnt_done,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               carry_q, carry_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               done;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

`ifdef MULT_INT_CNT_EN
  logic unused_cnt_done;
  assign unused_cnt_done = cnt_done;

  mult_step_cnt #(
    .Width(WIDTH)
  ) u_step_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .step (cnt_step),
    .done (done)
  );
`else
  assign done = cnt_done;
`endif

  // Add with carry kept, and the combined {carry, acc_hi, acc_lo} right shift.
  assign sum     = {1'b0, acc_hi_q} + {1'b0, mcand_q};
  assign shifted = {carry_q, acc_hi_q, acc_lo_q} >> 1;

  // Next-state, datapath updates and counter strobes.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    carry_d   = carry_q;
    product_d = product_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_hi_d = '0;
          acc_lo_d = '0;
          carry_d  = 1'b0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        cnt_load = 1'b1;
        state_d  = StAdd;
      end
      StAdd: begin
        if (mplier_q[0]) begin
          {carry_d, acc_hi_d} = sum;
        end
        state_d = StShift;
      end
      StShift: begin
        // Low product bits collect in acc_lo as the multiplier shifts out.
        {acc_hi_d, acc_lo_d} = shifted[2*WIDTH-1:0];
        carry_d  = 1'b0;
        mplier_d = mplier_q >> 1;
        if (done) begin
          state_d = StDone;
        end else begin
          cnt_step = 1'b1;
          state_d  = StAdd;
        end
      end
      StDone: begin
        product_d = {acc_hi_q, acc_lo_q};
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      carry_q   <= carry_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (WIDTH = 4) with an external counter model.
module tb_seq_mult_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cnt_load, cnt_step, busy, valid;
  logic [2*W-1:0] product;

  // Behavioural step counter feeding cnt_done.
  int   mdl_cnt = 0;
  logic mdl_done = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_load = 0;
  int n_step = 0;
  int n_both = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (op_a),
    .b       (op_b),
    .cnt_load(cnt_load),
    .cnt_step(cnt_step),
    .cnt_done(mdl_done),
    .busy    (busy),
    .valid   (valid),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_cnt  <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= (mdl_cnt == 0) && !cnt_load && !cnt_step;
      if (cnt_load) mdl_cnt <= W - 1;
      else if (cnt_step) mdl_cnt <= mdl_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (cnt_load) n_load++;
    if (cnt_step) n_step++;
    if (cnt_load && cnt_step) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: expect a*b exactly 2*W+2 cycles after the start edge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    @(negedge clk);
    op_a = av;
    op_b = bv;
    start = 1'b1;
    n_load = 0;
    n_step = 0;
    n_both = 0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_cleared", valid, 0);
    lat = 0;
    while (!valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 2 * W + 2);
    check("product", product, av * bv);
    check("busy_at_valid", busy, 0);
    check("load_pulses", n_load, 1);
    check("step_pulses", n_step, W - 1);
    check("strobe_overlap", n_both, 0);
  endtask

  initial begin
    int            k;
    logic [W-1:0]  a1, b1, a2, b2;
    logic [2*W-1:0] held;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_product", product, 0);
    check("rst_cnt_load", cnt_load, 0);
    check("rst_cnt_step", cnt_step, 0);
    rst_n = 1'b1;

    // Directed operands.
    run_op(4'd13, 4'd11);
    check("p_13x11", product, 8'd143);
    run_op(4'hF, 4'hF);
    check("p_FxF", product, 8'hE1);
    run_op(4'h0, 4'h9);
    run_op(4'h7, 4'h0);

    // Random operands against a*b.
    for (int i = 0; i < 8; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset during the second iteration's ADD.
    @(negedge clk);
    op_a = 4'd9;
    op_b = 4'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_product", product, 0);
    check("midrst_load", cnt_load, 0);
    check("midrst_step", cnt_step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd5, 4'd12);

    // start held for 15 cycles: two back-to-back operations.
    a1 = 4'($urandom_range(1, 15));
    b1 = 4'($urandom_range(1, 15));
    a2 = 4'($urandom_range(1, 15));
    b2 = 4'($urandom_range(1, 15));
    @(negedge clk);
    op_a = a1;
    op_b = b1;
    start = 1'b1;
    held = '0;
    for (k = 0; k <= 23; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        op_a = a2;
        op_b = b2;
      end
      if (k == 14) start = 1'b0;
      check($sformatf("held_valid_%0d", k), valid, (k == 10 || k >= 21) ? 1 : 0);
      if (k == 10) check("held_p1", product, a1 * b1);
      if (k == 11) check("held_busy2", busy, 1);
      if (k == 21) begin
        check("held_p2", product, a2 * b2);
        held = product;
      end
      if (k > 21) check($sformatf("held_stable_%0d", k), product, held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
